// File: rtl/counter_sequencer.sv
// Tick-paced 4-bit up/down sequencer with pause, terminal count and continuous restart.
// Latency: q/state update on the edge after a qualifying tick; no backpressure (level controls only).
module counter_sequencer #(
    parameter int DIV_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       dir,
    input  logic [3:0] load_val,
    input  logic [3:0] limit,
    input  logic [4:0] rate_sel,
    output logic [3:0] q,
    output logic       tick_out,
    output logic       running,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;

    state_t               st;
    logic [DIV_WIDTH-1:0] div;
    logic                 edge_q;
    logic [3:0]           lim_l;
    logic [4:0]           rate_l;

    logic       cur_bit;
    logic       tick;
    logic       latch;
    logic [3:0] q_next;

    assign cur_bit = div[rate_l];
    assign tick    = cur_bit & ~edge_q;
    assign q_next  = dir ? q + 4'd1 : q - 4'd1;
    assign latch   = ((st == IDLE) || (st == DONE)) && start && !stop && !clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= IDLE;
            q      <= 4'd0;
            div    <= '0;
            edge_q <= 1'b0;
            lim_l  <= 4'd0;
            rate_l <= 5'd0;
        end else begin
            div <= div + DIV_ONE;
            // On a relatch the edge register tracks the newly selected bit, so only a real edge ticks.
            edge_q <= latch ? div[rate_sel] : cur_bit;
            if (clear) begin
                st <= IDLE;
                q  <= 4'd0;
            end else begin
                case (st)
                    IDLE, DONE: begin
                        if (latch) begin
                            st     <= RUN;
                            q      <= load_val;
                            lim_l  <= limit;
                            rate_l <= rate_sel;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            st <= PAUSE;
                        end else if (tick) begin
                            q <= q_next;
                            if (q_next == lim_l) st <= DONE;
                        end
                    end
                    PAUSE: begin
                        if (!stop && start) st <= RUN;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign tick_out = (st == RUN) && tick && !stop && !clear && !reset;
    assign running  = (st == RUN);
    assign done     = (st == DONE);
    assign state    = st;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer; every run starts from reset so divider phase is known.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       dir = 1'b1;
    logic [3:0] load_val = 4'd0;
    logic [3:0] limit = 4'd0;
    logic [4:0] rate_sel = 5'd0;
    logic [3:0] q;
    logic       tick_out;
    logic       running;
    logic       done;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    counter_sequencer #(.DIV_WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .dir      (dir),
        .load_val (load_val),
        .limit    (limit),
        .rate_sel (rate_sel),
        .q        (q),
        .tick_out (tick_out),
        .running  (running),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic start_run(input logic [3:0] lv, input logic [3:0] lim,
                             input logic [4:0] rs, input logic d);
        load_val = lv;
        limit    = lim;
        rate_sel = rs;
        dir      = d;
        start    = 1'b1;
        step();
        start    = 1'b0;
        #1;
    endtask

    // Waits for the next tick, checks how many cycles it took, then checks q after the edge.
    task automatic tick_step(input string tag, input logic [3:0] exp_q, input int exp_gap);
        int waited;
        waited = 0;
        while (tick_out !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        chk({tag, "_tick"}, {31'd0, tick_out}, 32'd1);
        chk({tag, "_gap"}, waited, exp_gap);
        step();
        chk({tag, "_q"}, {28'd0, q}, {28'd0, exp_q});
    endtask

    initial begin
        logic seen;
        int   waited;

        // Reset values, then count up 2..5 at rate 0
        do_reset();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_q", {28'd0, q}, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_tick", {31'd0, tick_out}, 32'd0);
        start_run(4'd2, 4'd5, 5'd0, 1'b1);
        chk("up_state", {30'd0, state}, 32'd1);
        chk("up_load", {28'd0, q}, 32'd2);
        chk("up_running", {31'd0, running}, 32'd1);
        tick_step("up3", 4'd3, 0);
        tick_step("up4", 4'd4, 1);
        tick_step("up5", 4'd5, 1);
        chk("up_done_state", {30'd0, state}, 32'd3);
        chk("up_done", {31'd0, done}, 32'd1);
        chk("up_done_running", {31'd0, running}, 32'd0);
        repeat (4) step();
        chk("up_hold_q", {28'd0, q}, 32'd5);

        // Count down through the 0 -> 15 wrap
        do_reset();
        start_run(4'd1, 4'd14, 5'd0, 1'b0);
        chk("dn_load", {28'd0, q}, 32'd1);
        tick_step("dn0", 4'd0, 0);
        tick_step("dn15", 4'd15, 1);
        tick_step("dn14", 4'd14, 1);
        chk("dn_done_state", {30'd0, state}, 32'd3);

        // Pause at q=3 with stop landing on a tick cycle, then resume without reload
        do_reset();
        start_run(4'd2, 4'd9, 5'd0, 1'b1);
        tick_step("ps3", 4'd3, 0);
        step();
        stop = 1'b1;
        #1;
        chk("ps_tick_gated", {31'd0, tick_out}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen = seen | tick_out;
        end
        chk("ps_state", {30'd0, state}, 32'd2);
        chk("ps_q_hold", {28'd0, q}, 32'd3);
        chk("ps_no_tick", {31'd0, seen}, 32'd0);
        stop     = 1'b0;
        load_val = 4'd11;
        start    = 1'b1;
        step();
        start    = 1'b0;
        #1;
        chk("rs_state", {30'd0, state}, 32'd1);
        chk("rs_q_noreload", {28'd0, q}, 32'd3);
        tick_step("rs4", 4'd4, 1);

        // load == limit: full 16-tick wrap at rate 1
        do_reset();
        start_run(4'd7, 4'd7, 5'd1, 1'b1);
        chk("wr_state", {30'd0, state}, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            tick_step("wr", 4'((7 + i) % 16), (i == 1) ? 1 : 3);
            if (i == 15) chk("wr_still_run", {30'd0, state}, 32'd1);
        end
        chk("wr_done_state", {30'd0, state}, 32'd3);
        chk("wr_done_q", {28'd0, q}, 32'd7);

        // clear beats start in RUN; reset on a tick cycle
        do_reset();
        start_run(4'd2, 4'd9, 5'd0, 1'b1);
        tick_step("cl3", 4'd3, 0);
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        chk("cl_state", {30'd0, state}, 32'd0);
        chk("cl_q", {28'd0, q}, 32'd0);
        start_run(4'd4, 4'd9, 5'd0, 1'b1);
        waited = 0;
        while (tick_out !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        chk("rt_found_tick", {31'd0, tick_out}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rt_tick_gated", {31'd0, tick_out}, 32'd0);
        step();
        chk("rt_state", {30'd0, state}, 32'd0);
        chk("rt_q", {28'd0, q}, 32'd0);
        chk("rt_running", {31'd0, running}, 32'd0);
        chk("rt_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // rate_sel change mid-run is ignored until the next latch
        do_reset();
        start_run(4'd0, 4'd4, 5'd0, 1'b1);
        tick_step("rc1", 4'd1, 0);
        rate_sel = 5'd3;
        tick_step("rc2", 4'd2, 1);
        tick_step("rc3", 4'd3, 1);
        tick_step("rc4", 4'd4, 1);
        chk("rc_done_state", {30'd0, state}, 32'd3);
        start_run(4'd0, 4'd2, 5'd3, 1'b1);
        chk("rc_restart_state", {30'd0, state}, 32'd1);
        tick_step("rs1", 4'd1, 15);
        tick_step("rs2", 4'd2, 15);
        chk("rc_final_state", {30'd0, state}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
